imm_encode_loader: RTL

- Inverse of the pipeline's immediate generator. Accepts (base instruction, immediate, ImmSel) records over a valid/ready stream.
- Scatters the immediate into the RISC-V U/I/S/B/J field positions of the base word and range-checks it.
- Writes the finished 32-bit words to consecutive instruction-memory addresses.
- Used as a boot-time/test program loader in front of instruction memory.

---
 rtl/imm_encode_pkg.sv | 30 +++
 rtl/imm_field_pack.sv | 80 ++++++++
 rtl/imm_encode_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/imm_encode_pkg.sv
// Shared constants, state encoding and helpers for the immediate encode loader.
package imm_encode_pkg;

  localparam logic [2:0] IMM_U = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_RANGE = 3'd1;
  localparam logic [2:0] ERR_ALIGN = 3'd2;
  localparam logic [2:0] ERR_SEL   = 3'd3;
  localparam logic [2:0] ERR_RT    = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // True when bits [31:msb] of v are all equal, i.e. v fits a signed field ending at msb.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] t;
    t = 32'($signed(v) >>> msb);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Scatters an immediate into its RISC-V field positions and range/alignment checks it.
// ROUNDTRIP_CHECK_EN adds a decode-back comparison reported as ERR_RT.
module imm_field_pack
  import imm_encode_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [2:0]  immsel,
  output logic [31:0] word_c,
  output logic [2:0]  code_c
);

  logic [31:0] field;
  logic [2:0]  chk_code;

  always_comb begin
    field    = '0;
    chk_code = ERR_NONE;
    case (immsel)
      IMM_U: begin
        field = {imm[31:12], 12'b0};
        if (imm[11:0] != '0) chk_code = ERR_ALIGN;
      end
      IMM_I: begin
        field = {imm[11:0], 20'b0};
        if (!sext_fits(imm, 11)) chk_code = ERR_RANGE;
      end
      IMM_S: begin
        field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        if (!sext_fits(imm, 11)) chk_code = ERR_RANGE;
      end
      IMM_B: begin
        field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        if (!sext_fits(imm, 12))  chk_code = ERR_RANGE;
        else if (imm[0])          chk_code = ERR_ALIGN;
      end
      IMM_J: begin
        field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        if (!sext_fits(imm, 20))  chk_code = ERR_RANGE;
        else if (imm[0])          chk_code = ERR_ALIGN;
      end
      default: chk_code = ERR_SEL;
    endcase
  end

  assign word_c = base | field;

`ifdef ROUNDTRIP_CHECK_EN
  logic [31:0] dec;
  logic [31:0] want;

  // Re-extract the immediate the way the pipeline's immediate generator would.
  always_comb begin
    dec  = '0;
    want = imm;
    case (immsel)
      IMM_U: begin
        dec  = {word_c[31:12], 12'b0};
        want = {imm[31:12], 12'b0};
      end
      IMM_I: dec = {{20{word_c[31]}}, word_c[31:20]};
      IMM_S: dec = {{20{word_c[31]}}, word_c[31:25], word_c[11:7]};
      IMM_B: begin
        dec  = {{19{word_c[31]}}, word_c[31], word_c[7], word_c[30:25], word_c[11:8], 1'b0};
        want = {imm[31:1], 1'b0};
      end
      IMM_J: begin
        dec  = {{11{word_c[31]}}, word_c[31], word_c[19:12], word_c[20], word_c[30:21], 1'b0};
        want = {imm[31:1], 1'b0};
      end
      default: dec = imm;
    endcase
  end

  assign code_c = (chk_code == ERR_NONE && dec != want) ? ERR_RT : chk_code;
`else
  assign code_c = chk_code;
`endif

endmodule

// File: rtl/imm_encode_loader.sv
// Boot/test program loader: encodes (base, imm, ImmSel) records and writes them to instruction memory.
// Optional decode-back check enabled by ROUNDTRIP_CHECK_EN (see imm_field_pack).
module imm_encode_loader
  import imm_encode_pkg::*;
#(
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_immsel,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] err_idx
);

  state_t state, state_d;

  logic [CNT_W-1:0] cnt_r, acc_cnt, wr_cnt;
  logic [31:0]      nxt_addr;

  logic             s1_v;
  logic [31:0]      s1_word, s1_addr;
  logic [2:0]       s1_code;
  logic [CNT_W-1:0] s1_idx;

  logic [31:0] pk_word;
  logic [2:0]  pk_code;

  logic start_acc, in_fire, s2_free, s1_adv, s1_fail, wr_fire, last_wr;

  imm_field_pack u_pack (
    .base   (in_base),
    .imm    (in_imm),
    .immsel (in_immsel),
    .word_c (pk_word),
    .code_c (pk_code)
  );

  assign start_acc = start && (state == IDLE || state == ERR);
  assign s2_free   = !mem_we || mem_ready;
  assign s1_adv    = (state == RUN) && s1_v && (s1_code == ERR_NONE) && s2_free;
  assign s1_fail   = (state == RUN) && s1_v && (s1_code != ERR_NONE);
  assign wr_fire   = mem_we && mem_ready;
  assign last_wr   = wr_fire && (wr_cnt == cnt_r - CNT_W'(1));
  assign in_ready  = (state == RUN) && (acc_cnt < cnt_r) && (!s1_v || s1_adv);
  assign in_fire   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, ERR: if (start) state_d = (count == '0) ? DONE : RUN;
      RUN: begin
        if (s1_fail)      state_d = ERR;
        else if (last_wr) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run bookkeeping, S1/S2 pipeline and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      nxt_addr  <= '0;
      s1_v      <= 1'b0;
      s1_word   <= '0;
      s1_addr   <= '0;
      s1_code   <= ERR_NONE;
      s1_idx    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      err_idx   <= '0;
    end else begin
      if (start_acc) begin
        cnt_r    <= count;
        acc_cnt  <= '0;
        wr_cnt   <= '0;
        nxt_addr <= base_addr;
        err_code <= ERR_NONE;
        err_idx  <= '0;
      end else begin
        if (in_fire) begin
          acc_cnt  <= acc_cnt + CNT_W'(1);
          nxt_addr <= nxt_addr + 32'(ADDR_STEP);
        end
        if (wr_fire) wr_cnt <= wr_cnt + CNT_W'(1);
        if (s1_fail) begin
          err_code <= s1_code;
          err_idx  <= s1_idx;
        end
      end

      // A failing record is dropped from S1 instead of advancing.
      if (s1_fail) begin
        s1_v <= 1'b0;
      end else if (in_fire) begin
        s1_v    <= 1'b1;
        s1_word <= pk_word;
        s1_code <= pk_code;
        s1_addr <= nxt_addr;
        s1_idx  <= acc_cnt;
      end else if (s1_adv) begin
        s1_v <= 1'b0;
      end

      if (s2_free) begin
        mem_we <= s1_adv;
        if (s1_adv) begin
          mem_addr  <= s1_addr;
          mem_wdata <= s1_word;
        end
      end

      busy <= (state_d == RUN);
      done <= (state_d == DONE);
      err  <= (state_d == ERR);
    end
  end

endmodule
